// File: rtl/modn_counter_if.sv
`default_nettype none
// ============================================================================
// modn_counter_if : control/status bundle of a modulo-N counter stage
// Revision: 1.0
// ============================================================================
interface modn_counter_if #(
   parameter int WIDTH = 3
);
   logic             en;
   logic             up_dn;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
   logic             load_err;

   modport master (
      output en, up_dn, clr, load, load_val,
      input  count, tc, wrap, load_err
   );

   modport slave (
      input  en, up_dn, clr, load, load_val,
      output count, tc, wrap, load_err
   );
endinterface
`default_nettype wire

// File: rtl/modn_counter.sv
`default_nettype none
// ============================================================================
// modn_counter : modulo-N up/down counter with load, clear and cascade outputs
// Revision: 1.0
// ============================================================================
module modn_counter #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 6
) (
   input  wire logic     clk,
   input  wire logic     rst,
   modn_counter_if.slave bus
);

   generate
      if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
         $error("modn_counter: MODULUS out of range for WIDTH");
      end
   endgenerate

   localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   c_mod = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             r_load_err;

   logic [WIDTH-1:0] w_next_count;
   logic             w_next_wrap;
   logic             w_next_err;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_load_ok;

   assign w_at_max  = (r_count == c_max);
   assign w_at_zero = (r_count == '0);
   // One extra bit so MODULUS == 2**WIDTH compares correctly
   assign w_load_ok = ({1'b0, bus.load_val} < c_mod);

   always_comb begin
      w_next_count = r_count;
      w_next_wrap  = 1'b0;
      w_next_err   = r_load_err;
      if (bus.clr) begin
         w_next_count = '0;
         w_next_err   = 1'b0;
      end else if (bus.load) begin
         if (w_load_ok) begin
            w_next_count = bus.load_val;
         end else begin
            w_next_err = 1'b1;
         end
      end else if (bus.en) begin
         if (bus.up_dn) begin
            if (w_at_max) begin
               w_next_count = '0;
               w_next_wrap  = 1'b1;
            end else begin
               w_next_count = r_count + 1'b1;
            end
         end else begin
            if (w_at_zero) begin
               w_next_count = c_max;
               w_next_wrap  = 1'b1;
            end else begin
               w_next_count = r_count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count    <= '0;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_count    <= w_next_count;
         r_wrap     <= w_next_wrap;
         r_load_err <= w_next_err;
      end
   end

   assign bus.count    = r_count;
   assign bus.wrap     = r_wrap;
   assign bus.load_err = r_load_err;
   // Carry/borrow-out for the next stage's en
   assign bus.tc = bus.en & ~bus.clr & ~bus.load &
                   ((bus.up_dn & w_at_max) | (~bus.up_dn & w_at_zero));

endmodule
`default_nettype wire

// File: doc/modn_counter.md
# modn_counter

Parametrised modulo-N binary counter. It generalises the fixed mod-6 up counter to any modulus with up/down counting, synchronous load and clear, count enable, and cascade outputs. It is the counter primitive used for dividers, timers and multi-digit chains (BCD digits, clock/time counters) in the counter library.

## Interface

**Parameters**
- WIDTH, default 3: counter width in bits.
- MODULUS, default 6: count range is 0 to MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH. Elaboration fails outside this range.

**Ports**
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: count enable. Also the cascade carry-in from the previous stage.
- up_dn, input, 1: 1 counts up, 0 counts down.
- clr, input, 1: synchronous clear to 0.
- load, input, 1: synchronous load of load_val.
- load_val, input, WIDTH: value to load.
- count, output, WIDTH: current count, registered.
- tc, output, 1: terminal count, combinational. Used as carry/borrow-out to the next stage's en.
- wrap, output, 1: registered one-cycle pulse, asserted the cycle after a wrap occurred.
- load_err, output, 1: sticky flag, set by an out-of-range load.

## Operation

- **Update priority per rising edge:** rst (async) > clr > load > en > hold.
- **clr=1:** count ← 0, load_err ← 0, wrap ← 0.
- **load=1 (clr=0):**
  - load_val < MODULUS: count ← load_val.
  - load_val ≥ MODULUS: count holds and load_err ← 1.
  - Either way, wrap ← 0 and en is ignored that cycle.
- **en=1, up_dn=1:**
  - count == MODULUS-1: count ← 0, wrap ← 1.
  - Otherwise: count ← count+1, wrap ← 0.
- **en=1, up_dn=0:**
  - count == 0: count ← MODULUS-1, wrap ← 1.
  - Otherwise: count ← count-1, wrap ← 0.
- **en=0:** count holds, wrap ← 0.
- **tc** = en & ~clr & ~load & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)). It is high exactly in the cycle whose edge will wrap.
- **Count range:** count never leaves 0..MODULUS-1. All arithmetic is WIDTH bits with no overflow, including when MODULUS = 2^WIDTH, where the up wrap from all-ones to 0 is the natural rollover.
- **Direction change:** up_dn may change on any cycle. The next edge uses the new direction. There is no extra latency and no lost count.
- **Cascading:** connecting stage k's tc to stage k+1's en (with shared clk/rst/up_dn) yields a correct multi-digit up/down counter.
- **load_err:** cleared only by clr or rst. A subsequent valid load does not clear it.

## Timing

- **Reset values (immediate on rst rising, independent of clk):** count=0, wrap=0, load_err=0. tc then follows its equation, so it may be 1 if en=1 and up_dn=0.
- **Reset release:** the first edge with rst=0 performs a normal update.
- **Reset mid-count:** the count is lost and there is no partial update.
- **Latency:**
  - count: 1 clock from en/load/clr.
  - wrap: asserted in the same cycle the new count (0 or MODULUS-1) is visible, for exactly 1 cycle per wrap.
  - tc: zero latency (combinational from en, up_dn, clr, load, count).
- **Continuous counting:** with en held high, wrap pulses every MODULUS cycles.
- **Simultaneous events:**
  - clr+load+en: clr wins.
  - load+en at terminal: load wins, no wrap pulse, tc=0.
- **Glitch requirement:** tc must be glitch-tolerant for synchronous use only. It is not a clock.

## Test plan

- **Reset and up count (WIDTH=3, MODULUS=6):** Pulse rst mid-cycle → count=0 immediately. Then en=1, up_dn=1 for 13 cycles → count 1,2,3,4,5,0,1,…,1. wrap is high in the cycles showing 0 (after edges 6 and 12). tc is high while count=5.
- **Down count with direction change:** From count=0, apply en=1, up_dn=0 → tc=1, next count=5, wrap=1. Continue 5,4,3. Then set up_dn=1 → 4,5,0.
- **Load and error:** load_val=4, load=1 → count=4. Then load_val=7 → count stays 4, load_err=1. Then load_val=2 → count=2, load_err stays 1. Then clr=1 → count=0, load_err=0.
- **Priority:** At count=5, up_dn=1, assert clr=1, load=1 (load_val=3) and en=1 together → count=0, wrap=0, tc=0. Repeat with clr=0 → count=3, wrap=0.
- **Full-range and cascade:** WIDTH=4, MODULUS=16, en=1 → rollover from 15 to 0 with wrap=1. Build a two-stage chain of MODULUS=10 stages (tc→en) and run 100 up edges from 0 → both stages read 0, and the upper stage wraps once. Run 1 down edge → both stages read 9.
- **Async reset during activity:** Assert rst between edges while count=3 and load_err=1 → all outputs reset without a clock edge. Deassert rst → the next edge counts from 0 to 1.
